// File: rtl/vv_acc_pkg.sv
// Shared types and constants for the vector voltmeter accumulation sequencer.
package vv_acc_pkg;

  // Encodings are visible on the state output and must stay fixed.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReset = 2'd1,
    StArmed = 2'd2,
    StRun   = 2'd3
  } acc_state_e;

  // Bit positions inside the software control word.
  localparam int unsigned CTRL_RST  = 0;
  localparam int unsigned CTRL_ARM  = 1;
  localparam int unsigned CTRL_FREE = 2;

endpackage

// File: rtl/vv_acc_sequencer_if.sv
// Control/status bundle between the register bank and the accumulation sequencer.
interface vv_acc_sequencer_if #(
  parameter int unsigned LEN_W = 32,
  parameter int unsigned CNT_W = 32
);

  logic [31:0]      sw_ctrl;
  logic [LEN_W-1:0] acc_len;
  logic             sync_in;
  logic             valid_in;
  logic             cnt_rst;
  logic             acc_en;
  logic             acc_new;
  logic [CNT_W-1:0] acc_cnt;
  logic [1:0]       state;
  logic             busy;

  // Register-bank / stimulus side.
  modport master (
    output sw_ctrl, acc_len, sync_in, valid_in,
    input  cnt_rst, acc_en, acc_new, acc_cnt, state, busy
  );

  // Sequencer side.
  modport slave (
    input  sw_ctrl, acc_len, sync_in, valid_in,
    output cnt_rst, acc_en, acc_new, acc_cnt, state, busy
  );

endinterface

// File: rtl/vv_edge_det.sv
// Registered rising-edge detector; history resets to all-ones so levels already
// high when reset releases do not count as edges.
module vv_edge_det #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] rise_q, rise_d;

  // Next history and edge flags.
  always_comb begin
    prev_d = d_i;
    rise_d = d_i & ~prev_q;
  end

  // History and edge flag registers, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= '1;
      rise_q <= '0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/vv_acc_sequencer.sv
// Accumulation sequencer: turns software reset/arm requests plus sync into the
// counter-reset pulse, accumulation window enable and end-of-window strobe.
module vv_acc_sequencer
  import vv_acc_pkg::*;
#(
  parameter int unsigned LEN_W         = 32,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned RST_PULSE_LEN = 4
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  vv_acc_sequencer_if.slave   bus
);

  localparam int unsigned PW = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;
  localparam logic [PW-1:0] PulseLast = PW'(RST_PULSE_LEN - 1);

  logic [1:0]       rise;
  logic             rst_edge, arm_edge;
  acc_state_e       state_q, state_d;
  logic [PW-1:0]    pulse_q, pulse_d;
  logic [LEN_W-1:0] samp_q, samp_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_new_q, acc_new_d;
  logic             cnt_rst_q, acc_en_q, busy_q;
  logic             unused_ctrl;

  assign unused_ctrl = ^bus.sw_ctrl[31:3];

  vv_edge_det #(
    .WIDTH (2)
  ) u_edge_det (
    .clk_i  (user_clk),
    .rst_ni (user_rst_n),
    .d_i    (bus.sw_ctrl[CTRL_ARM:CTRL_RST]),
    .rise_o (rise)
  );

  assign rst_edge = rise[CTRL_RST];
  assign arm_edge = rise[CTRL_ARM];

  // Sequencer next state; a reset request overrides everything else, including
  // a window completing on the same cycle.
  always_comb begin
    state_d   = state_q;
    pulse_d   = pulse_q;
    samp_d    = samp_q;
    len_d     = len_q;
    acc_cnt_d = acc_cnt_q;
    acc_new_d = 1'b0;
    if (rst_edge) begin
      state_d   = StReset;
      pulse_d   = '0;
      samp_d    = '0;
      len_d     = '0;
      acc_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arm_edge) state_d = StArmed;
        end
        StReset: begin
          if (pulse_q == PulseLast) state_d = StIdle;
          else                      pulse_d = pulse_q + PW'(1);
        end
        StArmed: begin
          if (bus.sync_in || bus.sw_ctrl[CTRL_FREE]) begin
            state_d = StRun;
            len_d   = (bus.acc_len == '0) ? LEN_W'(1) : bus.acc_len;
            samp_d  = '0;
          end
        end
        StRun: begin
          if (arm_edge) begin
            // Re-arm drops the partial window but keeps the completed count.
            state_d = StArmed;
            samp_d  = '0;
          end else if (bus.valid_in) begin
            if (samp_q == len_q - LEN_W'(1)) begin
              acc_new_d = 1'b1;
              samp_d    = '0;
              acc_cnt_d = acc_cnt_q + CNT_W'(1);
            end else begin
              samp_d = samp_q + LEN_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State, counters and registered outputs derived from the next state.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q   <= StIdle;
      pulse_q   <= '0;
      samp_q    <= '0;
      len_q     <= '0;
      acc_cnt_q <= '0;
      acc_new_q <= 1'b0;
      cnt_rst_q <= 1'b0;
      acc_en_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      samp_q    <= samp_d;
      len_q     <= len_d;
      acc_cnt_q <= acc_cnt_d;
      acc_new_q <= acc_new_d;
      cnt_rst_q <= (state_d == StReset);
      acc_en_q  <= (state_d == StRun);
      busy_q    <= (state_d != StIdle);
    end
  end

  assign bus.state   = state_q;
  assign bus.cnt_rst = cnt_rst_q;
  assign bus.acc_en  = acc_en_q;
  assign bus.acc_new = acc_new_q;
  assign bus.acc_cnt = acc_cnt_q;
  assign bus.busy    = busy_q;

endmodule
